// File: rtl/msu_data_fetch.sv
// Byte prefetch ring between the MSU data port and a 16-bit little-endian memory.
// A seek flushes the ring; a read still in flight at seek time completes and its data is dropped.
module msu_data_fetch #(
   parameter int DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] msu_data_addr,
   input  logic        msu_data_seek,
   input  logic        msu_data_req,
   output logic [7:0]  msu_data_out,
   output logic        msu_data_busy,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [15:0] mem_din,
   input  logic        mem_ack
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FETCH_LIMIT = LW'(DEPTH - 2);

   logic [7:0]    buffer [DEPTH];
   logic [PW-1:0] rd_ptr, rd_ptr_nx;
   logic [PW-1:0] wr_ptr, wr_ptr_nx;
   logic [LW-1:0] level, level_nx;
   logic [31:0]   fetch_addr, fetch_addr_nx;
   logic [31:0]   mem_addr_nx;
   logic          mem_rd_nx;
   logic          seek_pending, seek_pending_nx;
   logic          discard, discard_nx;
   logic          odd_skip, odd_skip_nx;
   logic          fetch_en, fetch_en_nx;
   logic [7:0]    out_nx;
   logic          busy_nx;

   logic          ack_live;
   logic          take_word;
   logic          consume;
   logic          wr0_en, wr1_en;
   logic [PW-1:0] wp0, wp1;
   logic [7:0]    wd0;

   always_comb begin
      rd_ptr_nx       = rd_ptr;
      wr_ptr_nx       = wr_ptr;
      level_nx        = level;
      fetch_addr_nx   = fetch_addr;
      mem_addr_nx     = mem_addr;
      mem_rd_nx       = mem_rd;
      seek_pending_nx = seek_pending;
      discard_nx      = discard;
      odd_skip_nx     = odd_skip;
      fetch_en_nx     = fetch_en;
      out_nx          = msu_data_out;

      ack_live  = mem_ack & mem_rd;
      take_word = ack_live & ~discard & ~msu_data_seek;
      consume   = msu_data_req & ~msu_data_seek & ~seek_pending & (level != '0);

      wp0    = wr_ptr;
      wp1    = wr_ptr + PW'(1);
      wd0    = odd_skip ? mem_din[15:8] : mem_din[7:0];
      wr0_en = take_word;
      wr1_en = take_word & ~odd_skip;

      if (msu_data_seek) begin
         level_nx        = '0;
         rd_ptr_nx       = '0;
         wr_ptr_nx       = '0;
         fetch_addr_nx   = {msu_data_addr[31:1], 1'b0};
         odd_skip_nx     = msu_data_addr[0];
         seek_pending_nx = 1'b1;
         fetch_en_nx     = 1'b1;
         // A read still waiting for its ack must keep its address until the ack, then be dropped.
         if (mem_rd && !mem_ack) begin
            discard_nx = 1'b1;
         end else begin
            discard_nx  = 1'b0;
            mem_rd_nx   = 1'b1;
            mem_addr_nx = {msu_data_addr[31:1], 1'b0};
         end
      end else begin
         if (take_word) begin
            level_nx        = level + LW'(odd_skip ? 1 : 2) - LW'(consume);
            wr_ptr_nx       = wr_ptr + PW'(odd_skip ? 1 : 2);
            fetch_addr_nx   = fetch_addr + 32'd2;
            odd_skip_nx     = 1'b0;
            seek_pending_nx = 1'b0;
            mem_rd_nx       = 1'b0;
         end else if (ack_live) begin
            discard_nx  = 1'b0;
            mem_rd_nx   = 1'b1;
            mem_addr_nx = fetch_addr;
            level_nx    = level - LW'(consume);
         end else begin
            level_nx = level - LW'(consume);
            if (!mem_rd && fetch_en && !seek_pending && (level <= FETCH_LIMIT)) begin
               mem_rd_nx   = 1'b1;
               mem_addr_nx = fetch_addr;
            end
         end
         if (consume) begin
            rd_ptr_nx = rd_ptr + PW'(1);
         end
      end

      // The head may be a byte landing on this very edge, so bypass the ring for it.
      if (level_nx != '0) begin
         if (wr0_en && (rd_ptr_nx == wp0)) begin
            out_nx = wd0;
         end else if (wr1_en && (rd_ptr_nx == wp1)) begin
            out_nx = mem_din[15:8];
         end else begin
            out_nx = buffer[rd_ptr_nx];
         end
      end

      busy_nx = seek_pending_nx | (level_nx == '0);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         level         <= '0;
         fetch_addr    <= '0;
         mem_addr      <= '0;
         mem_rd        <= 1'b0;
         seek_pending  <= 1'b0;
         discard       <= 1'b0;
         odd_skip      <= 1'b0;
         fetch_en      <= 1'b0;
         msu_data_out  <= '0;
         msu_data_busy <= 1'b1;
      end else begin
         rd_ptr        <= rd_ptr_nx;
         wr_ptr        <= wr_ptr_nx;
         level         <= level_nx;
         fetch_addr    <= fetch_addr_nx;
         mem_addr      <= mem_addr_nx;
         mem_rd        <= mem_rd_nx;
         seek_pending  <= seek_pending_nx;
         discard       <= discard_nx;
         odd_skip      <= odd_skip_nx;
         fetch_en      <= fetch_en_nx;
         msu_data_out  <= out_nx;
         msu_data_busy <= busy_nx;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr0_en) begin
         buffer[wp0] <= wd0;
      end
      if (wr1_en) begin
         buffer[wp1] <= mem_din[15:8];
      end
   end

endmodule

// File: doc/msu_data_fetch.md
MSU_DATA_FETCH -- requirements
Module: msu_data_fetch

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 8, the byte capacity of the prefetch buffer (power of two, minimum 4).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports CLK and RST_N.
REQ-003 CLK  in  1  system clock; all state changes on its rising edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 msu_data_addr  in  32  byte address from the MSU register block; sampled only on msu_data_seek.
REQ-006 msu_data_seek  in  1  one-cycle pulse: flush the buffer and restart fetching at msu_data_addr.
REQ-007 msu_data_req  in  1  one-cycle pulse: consume the head byte.
REQ-008 msu_data_out  out  8  head byte of the buffer; feeds the MSU msu_data_in port.
REQ-009 msu_data_busy  out  1  high while seeking or while the buffer is empty; feeds msu_status_data_busy.
REQ-010 mem_rd  out  1  read request level; held until mem_ack.
REQ-011 mem_addr  out  32  byte address of the 16-bit word being read; bit 0 always 0; stable while mem_rd is high.
REQ-012 mem_din  in  16  read data, little-endian: [7:0] is the even byte and [15:8] is the odd byte.
REQ-013 mem_ack  in  1  one-cycle pulse: mem_din is valid and the request is complete.

Function
REQ-014 Buffer: DEPTH-byte ring with read pointer, write pointer and level counter (0..DEPTH); both pointers wrap modulo DEPTH.
REQ-015 msu_data_out SHALL be registered and equal buffer[rd_ptr] whenever level>0; it SHALL hold its last value when level==0.
REQ-016 msu_data_busy SHALL equal (seek_pending | level==0), registered.
REQ-017 Fetch rule: when no read is outstanding, seek_pending==0 and level<=DEPTH-2, the block SHALL assert mem_rd the next cycle with mem_addr=fetch_addr.
REQ-018 On mem_ack for a non-discarded read, the block SHALL write both bytes (low then high), add 2 to level and advance fetch_addr by 2.
REQ-019 Exception: on the first word after a seek to an odd address, the block SHALL drop byte [7:0] and write only [15:8] (level +1).
REQ-020 fetch_addr SHALL wrap 0xFFFFFFFE -> 0x00000000.
REQ-021 Seek at cycle N: the block SHALL set level=0, rd_ptr=wr_ptr=0, fetch_addr={addr[31:1],0}, latch odd_skip=addr[0], and drive busy=1 from N+1.
REQ-022 With no read outstanding at seek, mem_rd SHALL rise at N+1.
REQ-023 Seek while a read is outstanding: the block SHALL set the discard flag and keep mem_rd/mem_addr stable until mem_ack. That ack SHALL be dropped (no buffer write), and the new read SHALL be issued the cycle after it.
REQ-024 seek_pending SHALL clear on the first post-seek non-discarded ack. busy SHALL fall and msu_data_out SHALL be valid the cycle after that ack.
REQ-025 req with level>0: the block SHALL advance rd_ptr, decrement level, and present the next byte on the following cycle.
REQ-026 req with level==0 or seek_pending==1 SHALL be ignored (no pointer change).
REQ-027 req and ack in the same cycle: level SHALL change by +2-1 (or +1-1 for an odd first word), with no byte lost.
REQ-028 seek and req in the same cycle: seek wins and req is ignored.
REQ-029 seek and ack in the same cycle: the ack is treated as discarded, and the new read SHALL be issued the next cycle.
REQ-030 mem_ack with no outstanding read SHALL be ignored.
REQ-031 The buffer SHALL never overflow: no read is issued unless 2 bytes are free at issue time.

Reset
REQ-032 While RST_N is low: mem_rd=0, mem_addr=0, msu_data_out=0, msu_data_busy=1, level=0, pointers=0, fetch_addr=0, and seek_pending, discard and odd_skip all 0. No fetch SHALL occur until the first seek.
REQ-033 Reset asserted mid-read SHALL abandon the outstanding read; a mem_ack arriving after reset release SHALL be ignored.

Verification
REQ-034 Seek to 0x00000100, memory returns 0x3412 with ack 3 cycles later -> mem_rd at N+1 with mem_addr=0x100; busy falls the cycle after ack; out=0x12; req -> out=0x34.
REQ-035 Seek to 0x00000101, word 0xBBAA -> out=0xBB first; next fetch at 0x102.
REQ-036 Seek while the read at 0x200 is outstanding, then seek to 0x400 -> the 0x200 ack data is never output; next mem_addr=0x400; out equals the byte at 0x400.
REQ-037 Zero-latency memory (ack the cycle after mem_rd) -> level saturates at DEPTH-1 or DEPTH, never exceeds DEPTH. Then 64 back-to-back reqs -> byte sequence contiguous and correct, busy stays 0 except on underrun.
REQ-038 Seek to 0xFFFFFFFE, read 3 words -> mem_addr sequence FFFFFFFE, 00000000, 00000002.
REQ-039 RST_N pulsed low while mem_rd=1, then a late mem_ack -> outputs at reset values, buffer empty, busy=1, no mem_rd.
